// File: rtl/orb_ram_wr_arbiter.sv
// orb_ram_wr_arbiter
// Shares the orbit-frame RAM write port among NREQ packer blocks. Every
// requester rising edge is captured into a one-deep slot. A round-robin
// scheduler then issues one single-cycle RAM write per captured request.
// Optional feature macro: ORB_ARB_COLLISION_GUARD_EN. When it is defined, a
// write is held back while the frame reader addresses the same RAM word.
// The hold is bounded by GUARD_TO cycles.
module orb_ram_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 11,
  parameter int DW       = 12,
  parameter int GUARD_TO = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [AW-1:0]      rd_addr,
  input  logic               clr_flags,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_data,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    ovf_flag,
  output logic               coll_flag
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (GUARD_TO > 1) ? $clog2(GUARD_TO) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_WRITE} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   req_we_d_reg;
  logic [NREQ-1:0]   edge_det;
  logic [NREQ-1:0]   pend_reg, pend_next;
  logic [NREQ-1:0]   ovf_reg, ovf_next;
  logic              coll_reg, coll_next;
  logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]     sel_idx_reg, sel_idx_next;
  logic [AW-1:0]     sel_addr_reg, sel_addr_next;
  logic [DW-1:0]     sel_data_reg, sel_data_next;
  logic [CW-1:0]     gcnt_reg, gcnt_next;
  logic              ram_we_reg, ram_we_next;
  logic [AW-1:0]     ram_addr_reg, ram_addr_next;
  logic [DW-1:0]     ram_data_reg, ram_data_next;
  logic [NREQ-1:0]   req_ack_reg, req_ack_next;
  logic [AW-1:0]     slot_addr [NREQ];
  logic [DW-1:0]     slot_data [NREQ];
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   grant_mask;
  logic              guard_pass, guard_force;

  // Per-requester edge detect and one-deep capture slot
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
      logic [AW-1:0] addr_reg;
      logic [DW-1:0] data_reg;
      assign edge_det[gi]  = req_we[gi] & ~req_we_d_reg[gi];
      assign slot_addr[gi] = addr_reg;
      assign slot_data[gi] = data_reg;
      // Load the slot on the cycle the requester's enable rises
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          addr_reg <= '0;
          data_reg <= '0;
        end else if (edge_det[gi]) begin
          addr_reg <= req_addr[gi*AW +: AW];
          data_reg <= req_data[gi*DW +: DW];
        end
      end
    end
  endgenerate

  // Round-robin pick: first pending slot at or after rr_ptr, wrapping
  always_comb begin
    int j;
    j          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr_reg) + k) % NREQ;
      if (!pick_valid && pend_reg[j]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

`ifdef ORB_ARB_COLLISION_GUARD_EN
  // Hold the write while the reader sits on the same word. Force it through
  // once the counter has reached GUARD_TO-1.
  always_comb begin
    guard_force = (sel_addr_reg == rd_addr) && (gcnt_reg == CW'(GUARD_TO - 1));
    guard_pass  = (sel_addr_reg != rd_addr) || guard_force;
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  // Without the guard the write always goes out on the first GUARD cycle
  always_comb begin
    guard_force = 1'b0;
    guard_pass  = 1'b1;
  end
`endif

  // State register together with all scheduler and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      req_we_d_reg <= '0;
      pend_reg     <= '0;
      ovf_reg      <= '0;
      coll_reg     <= 1'b0;
      rr_ptr_reg   <= '0;
      sel_idx_reg  <= '0;
      sel_addr_reg <= '0;
      sel_data_reg <= '0;
      gcnt_reg     <= '0;
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
      req_ack_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      req_we_d_reg <= req_we;
      pend_reg     <= pend_next;
      ovf_reg      <= ovf_next;
      coll_reg     <= coll_next;
      rr_ptr_reg   <= rr_ptr_next;
      sel_idx_reg  <= sel_idx_next;
      sel_addr_reg <= sel_addr_next;
      sel_data_reg <= sel_data_next;
      gcnt_reg     <= gcnt_next;
      ram_we_reg   <= ram_we_next;
      ram_addr_reg <= ram_addr_next;
      ram_data_reg <= ram_data_next;
      req_ack_reg  <= req_ack_next;
    end
  end

  // Next-state logic and guard-wait counter
  always_comb begin
    state_next = state_reg;
    gcnt_next  = gcnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          state_next = S_GUARD;
          gcnt_next  = '0;
        end
      end
      S_GUARD: begin
        if (guard_pass) state_next = S_WRITE;
        else            gcnt_next  = gcnt_reg + 1'b1;
      end
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: slot bookkeeping, sticky flags, selection and write strobe
  always_comb begin
    grant_mask    = (state_reg == S_IDLE && pick_valid) ? (NREQ'(1) << pick_idx) : '0;
    // A new edge on the slot being taken this cycle re-arms it without overflow
    pend_next     = (pend_reg & ~grant_mask) | edge_det;
    ovf_next      = (clr_flags ? '0 : ovf_reg) | (edge_det & pend_reg & ~grant_mask);
    coll_next     = (clr_flags ? 1'b0 : coll_reg) | ((state_reg == S_GUARD) && guard_force);
    sel_idx_next  = sel_idx_reg;
    sel_addr_next = sel_addr_reg;
    sel_data_next = sel_data_reg;
    rr_ptr_next   = rr_ptr_reg;
    ram_we_next   = 1'b0;
    ram_addr_next = ram_addr_reg;
    ram_data_next = ram_data_reg;
    req_ack_next  = '0;
    if (state_reg == S_IDLE && pick_valid) begin
      sel_idx_next  = pick_idx;
      sel_addr_next = slot_addr[pick_idx];
      sel_data_next = slot_data[pick_idx];
    end
    if (state_reg == S_GUARD && guard_pass) begin
      ram_we_next   = 1'b1;
      ram_addr_next = sel_addr_reg;
      ram_data_next = sel_data_reg;
      req_ack_next  = NREQ'(1) << sel_idx_reg;
      rr_ptr_next   = (sel_idx_reg == IW'(NREQ - 1)) ? '0 : sel_idx_reg + 1'b1;
    end
  end

  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_data  = ram_data_reg;
  assign req_ack   = req_ack_reg;
  assign ovf_flag  = ovf_reg;
  assign coll_flag = coll_reg;

endmodule
